// File: rtl/output_port.sv
// Buffered output-write port: queues CPU output words in a first-word
// fall-through FIFO and raises hlt only after a halt request has fully drained it.
module output_port #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  halt_req,
  output logic                  full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  hlt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp_reg, rp_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic                  push, pop;

  assign full      = (count_reg == CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign hlt       = (state_reg == HALTED);

  // Writes are only honoured while running; DRAIN and HALTED silently ignore them.
  assign push = write && !full && (state_reg == RUN);
  assign pop  = out_valid && out_ready;

  // Head word shown only while valid so the consumer never sees stale memory.
  assign out_data = out_valid ? mem[rp_reg] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_reg] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_reg       <= '0;
      rp_reg       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= RUN;
    end else begin
      if (push) wp_reg <= wp_reg + 1'b1;
      if (pop)  rp_reg <= rp_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // A rejected write is flagged even when a pop frees a slot this same edge.
      if (write && full && (state_reg == RUN)) overflow_reg <= 1'b1;
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (halt_req) state_next = DRAIN;
      DRAIN:   if (count_reg == '0) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_output_port.sv
// Self-checking bench for output_port: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_output_port;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          write;
  logic [DW-1:0] data;
  logic          halt_req;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          hlt;

  output_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write(write), .data(data), .halt_req(halt_req),
    .full(full), .count(count), .overflow(overflow), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .hlt(hlt)
  );

  always #5 clk = ~clk;

  // Reference model: a word queue plus a phase number (0 run, 1 drain, 2 halted).
  logic [DW-1:0] q[$];
  int            m_phase;
  bit            m_ovf;
  int            passed;
  int            total;
  int            cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic check_all();
    logic [31:0] e_data;
    e_data = (q.size() != 0) ? 32'(q[0]) : 32'd0;
    chk("count",     32'(count),     32'(q.size()));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("out_data",  32'(out_data),  e_data);
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("hlt",       32'(hlt),       32'(m_phase == 2));
  endtask

  // One clock: drive inputs, advance the model on the edge, check 1 ns later.
  task automatic step(input bit rst, input bit wr, input logic [DW-1:0] d,
                      input bit hr, input bit rdy);
    int  size_before;
    bit  is_full;
    reset = rst; write = wr; data = d; halt_req = hr; out_ready = rdy;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_phase = 0;
      m_ovf   = 1'b0;
    end else begin
      size_before = q.size();
      is_full     = (size_before == DEPTH);
      if (rdy && size_before != 0) void'(q.pop_front());
      if (m_phase == 0 && wr) begin
        if (is_full) m_ovf = 1'b1;
        else q.push_back(d);
      end
      if (m_phase == 0 && hr) m_phase = 1;
      else if (m_phase == 1 && size_before == 0) m_phase = 2;
    end
    #1;
    check_all();
    $display("cyc %0d rst=%0b wr=%0b d=%h hr=%0b rdy=%0b -> cnt=%0d full=%0b ovf=%0b v=%0b od=%h hlt=%0b",
             cyc, rst, wr, d, hr, rdy, count, full, overflow, out_valid, out_data, hlt);
  endtask

  initial begin
    int k;
    passed = 0; total = 0; cyc = 0;
    m_phase = 0; m_ovf = 1'b0;
    reset = 1'b1; write = 1'b0; data = '0; halt_req = 1'b0; out_ready = 1'b0;

    // Reset and idle, then single word with one-cycle write-to-valid latency.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 16'h1234, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Fill to full, overflow on a ninth word, then drain in order.
    for (int i = 1; i <= 8; i++) step(0, 1, 16'(i), 0, 0);
    step(0, 1, 16'h0009, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1);

    // Sustained push+pop at count 3 across two pointer wraps.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'h00F0 + 16'(i), 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 16'h0100 + 16'(i), 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // Full with simultaneous pop and write: write rejected, overflow set, count 7.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 16'h0200 + 16'(i), 0, 0);
    step(0, 1, 16'h02FF, 0, 1);

    // Halt with 3 queued: writes ignored during drain, hlt once empty.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'h0300 + 16'(i), 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'h0EEE, 0, 0);
    k = 0;
    while (!hlt && k < 20) begin
      step(0, 1, 16'h0DDD, 0, 1);
      k++;
    end
    chk("halt_bound", 32'(k < 20), 32'd1);
    step(0, 1, 16'h0CCC, 1, 1);

    // Reset during DRAIN with two words queued, then normal delivery.
    step(1, 0, 0, 0, 0);
    step(0, 1, 16'h0401, 0, 0);
    step(0, 1, 16'h0402, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 16'hABCD, 0, 0);
    step(0, 0, 0, 0, 1);

    // Halt with an empty FIFO: hlt two edges after the request.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic with rare halts and resets.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0),
           16'($urandom), ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
